uart_rx_core: RTL

UART receiver core: the receive-direction counterpart of the APB UART transmitter path. It samples the serial line, decodes frames using the runtime config (clock divider, data bits, parity, stop bits) and emits one-cycle data pulses with error flags. It sits between the pad input and an rx FIFO / uart_reg feedback (fdb_dat_i, fdb_num_dat_i) inside a future uart_rx_with_apb. There is no backpressure; the downstream FIFO must absorb every pulse.

---
 rtl/uart_rx_core_pkg.sv | 31 +++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx_core.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared types and limits for the UART receive path.
package uart_rx_core_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  localparam int unsigned UART_DIV_MIN = 2;
  localparam int unsigned UART_BIT_MIN = 1;

  // Encoding 3 is reserved and behaves as no parity.
  function automatic parity_e clamp_parity(input logic [1:0] enc);
    case (enc)
      2'd1:    return PARITY_ODD;
      2'd2:    return PARITY_EVEN;
      default: return PARITY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input with falling-edge detect.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta;
  logic sync_d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= RST_VAL;
      sync    <= RST_VAL;
      sync_d1 <= RST_VAL;
    end else begin
      meta    <= din;
      sync    <= meta;
      sync_d1 <= sync;
    end
  end

  assign fall = !sync && sync_d1;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: samples the serial line at bit centres using a latched runtime
// config and emits a one-cycle val_o with the assembled data and error flags.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned DIV_WD  = 16,
  parameter int unsigned BIT_WD  = 4,
  parameter int unsigned BIT_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_WD-1:0]  cfg_num_div_clk_i,
  input  logic [BIT_WD-1:0]  cfg_num_bit_i,
  input  logic [1:0]         cfg_enm_parity_i,
  input  logic [1:0]         cfg_siz_stop_i,
  input  logic               uart_rx_i,
  output logic               val_o,
  output logic [BIT_MAX-1:0] dat_o,
  output logic               err_parity_o,
  output logic               err_frame_o,
  output logic               busy_o
);

  localparam logic [DIV_WD-1:0] DIV_MIN_W = DIV_WD'(UART_DIV_MIN);
  localparam logic [BIT_WD-1:0] BIT_MIN_W = BIT_WD'(UART_BIT_MIN);
  localparam logic [BIT_WD-1:0] BIT_MAX_W = BIT_WD'(BIT_MAX);

  rx_state_e state, state_n;

  logic rx_s;
  logic fall;

  logic [DIV_WD-1:0]  div_c;
  logic [BIT_WD-1:0]  nbit_c;
  logic [DIV_WD-1:0]  div_q;
  logic [BIT_WD-1:0]  nbit_q;
  parity_e            par_q;
  logic               two_stop_q;

  logic [DIV_WD-1:0]  timer;
  logic [BIT_WD-1:0]  cnt;
  logic               stop_cnt;
  logic [BIT_MAX-1:0] shreg;
  logic               perr;
  logic               ferr;

  logic timing;
  logic smp;
  logic start_frame;
  logic shift_en;
  logic par_en;
  logic stop_en;
  logic done;

  uart_rx_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (uart_rx_i),
    .sync (rx_s),
    .fall (fall)
  );

  always_comb begin
    div_c = cfg_num_div_clk_i;
    if (cfg_num_div_clk_i < DIV_MIN_W) div_c = DIV_MIN_W;
    nbit_c = cfg_num_bit_i;
    if (cfg_num_bit_i < BIT_MIN_W)      nbit_c = BIT_MIN_W;
    else if (cfg_num_bit_i > BIT_MAX_W) nbit_c = BIT_MAX_W;
  end

  assign timing = (state == RX_START) || (state == RX_DATA) ||
                  (state == RX_PARITY) || (state == RX_STOP);
  assign smp    = timing && (timer == '0);
  assign busy_o = (state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    done        = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          start_frame = 1'b1;
          state_n     = RX_START;
        end
      end
      RX_START: begin
        if (smp) state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (smp) begin
          shift_en = 1'b1;
          if (cnt == nbit_q - BIT_WD'(1))
            state_n = (par_q != PARITY_NONE) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (smp) begin
          par_en  = 1'b1;
          state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (smp) begin
          stop_en = 1'b1;
          if (stop_cnt == two_stop_q) begin
            done    = 1'b1;
            // A low final stop bit means the line may be in break; wait for it to recover.
            state_n = (ferr || !rx_s) ? RX_BREAK : RX_IDLE;
          end
        end
      end
      RX_BREAK: begin
        if (rx_s) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= DIV_MIN_W;
      nbit_q       <= BIT_MAX_W;
      par_q        <= PARITY_NONE;
      two_stop_q   <= 1'b0;
      timer        <= '0;
      cnt          <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      val_o        <= 1'b0;
      dat_o        <= '0;
      err_parity_o <= 1'b0;
      err_frame_o  <= 1'b0;
    end else begin
      val_o <= done;

      if (start_frame) begin
        div_q      <= div_c;
        nbit_q     <= nbit_c;
        par_q      <= clamp_parity(cfg_enm_parity_i);
        two_stop_q <= (cfg_siz_stop_i != 2'd0);
        timer      <= (div_c >> 1) - DIV_WD'(1);
        cnt        <= '0;
        stop_cnt   <= 1'b0;
        shreg      <= '0;
        perr       <= 1'b0;
        ferr       <= 1'b0;
      end else if (timing) begin
        timer <= smp ? (div_q - DIV_WD'(1)) : (timer - DIV_WD'(1));
      end

      if (shift_en) begin
        for (int unsigned i = 0; i < BIT_MAX; i++) begin
          if (cnt == BIT_WD'(i)) shreg[i] <= rx_s;
        end
        cnt <= cnt + BIT_WD'(1);
      end

      // Unused upper bits of shreg stay zero, so a full-width XOR is the data parity.
      if (par_en) begin
        if (par_q == PARITY_EVEN) perr <= ((^shreg) != rx_s);
        else                      perr <= ((^shreg) == rx_s);
      end

      if (stop_en) begin
        ferr     <= ferr | !rx_s;
        stop_cnt <= ~stop_cnt;
      end

      if (done) begin
        dat_o        <= shreg;
        err_parity_o <= perr;
        err_frame_o  <= ferr | !rx_s;
      end
    end
  end

endmodule
